// File: rtl/interval_timer_ctrl_pkg.sv
// Shared types for the interval timer: FSM state encoding and mode constants.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between software-facing registers and the interval timer.
interface interval_timer_ctrl_if #(parameter int WIDTH = 8);

   // Control inputs are single-cycle pulses except pause (level). irq is held
   // until irq_ack is seen for one cycle; a tick landing in the ack cycle wins.
   logic [WIDTH-1:0]     cfg_period;
   logic                 cfg_oneshot;
   logic                 start;
   logic                 stop;
   logic                 pause;
   logic                 irq_ack;
   logic [WIDTH-1:0]     cnt;
   logic                 busy;
   logic                 tick;
   logic                 done;
   logic                 irq;
   logic                 overrun;
   logic                 cfg_err;
   timer_pkg::state_t    dbg_state;

   modport master (
      output cfg_period, cfg_oneshot, start, stop, pause, irq_ack,
      input  cnt, busy, tick, done, irq, overrun, cfg_err, dbg_state
   );

   modport slave (
      input  cfg_period, cfg_oneshot, start, stop, pause, irq_ack,
      output cnt, busy, tick, done, irq, overrun, cfg_err, dbg_state
   );

endinterface

// File: rtl/interval_timer_ctrl_counter_en.sv
// WIDTH-bit up-counter with synchronous clear and enable; wraps at period-1.
module counter_en #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] cnt,
   output logic             term
);

   // Unqualified by en so the controller can use it without a comb loop.
   assign term = (cnt == period - WIDTH'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= term ? '0 : cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: run/pause/stop sequencing, tick
// generation and a sticky interrupt with overrun detection.
module interval_timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   interval_timer_ctrl_if.slave  bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] period_q;
   logic             mode_q;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             irq_q, irq_d;
   logic             ovr_q, ovr_d;
   logic             err_q, err_d;
   logic             load;
   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_term;
   logic [WIDTH-1:0] cnt;

   counter_en #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .period (period_q),
      .cnt    (cnt),
      .term   (cnt_term)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      tick_d  = 1'b0;
      done_d  = done_q;
      err_d   = 1'b0;
      irq_d   = irq_q;
      ovr_d   = ovr_q;

      if (bus.stop) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
         done_d  = 1'b0;
      end else if (bus.start) begin
         if (bus.cfg_period != '0) begin
            state_d = RUN;
            load    = 1'b1;
            cnt_clr = 1'b1;
            done_d  = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         case (state_q)
            RUN, HOLD: begin
               // Leaving HOLD counts on the same edge, so a pause of N cycles
               // delays the tick by exactly N.
               if (bus.pause) begin
                  state_d = HOLD;
               end else begin
                  state_d = RUN;
                  cnt_en  = 1'b1;
                  if (cnt_term) begin
                     tick_d = 1'b1;
                     if (mode_q == MODE_ONESHOT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      if (tick_d) begin
         irq_d = 1'b1;
         if (irq_q && !bus.irq_ack) begin
            ovr_d = 1'b1;
         end
      end else if (bus.irq_ack) begin
         irq_d = 1'b0;
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         period_q <= '0;
         mode_q   <= MODE_PERIODIC;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
         irq_q    <= 1'b0;
         ovr_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            period_q <= bus.cfg_period;
            mode_q   <= bus.cfg_oneshot;
         end
         tick_q <= tick_d;
         done_q <= done_d;
         irq_q  <= irq_d;
         ovr_q  <= ovr_d;
         err_q  <= err_d;
      end
   end

   assign bus.cnt       = cnt;
   assign bus.busy      = (state_q == RUN) || (state_q == HOLD);
   assign bus.tick      = tick_q;
   assign bus.done      = done_q;
   assign bus.irq       = irq_q;
   assign bus.overrun   = ovr_q;
   assign bus.cfg_err   = err_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: per-scenario tasks with an
// expected-output queue compared after every clock edge.
module tb_interval_timer_ctrl;
   import timer_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   logic [W+5:0] exp_q[$];
   logic [W+5:0] obs;
   logic [W+5:0] e;

   interval_timer_ctrl_if #(.WIDTH(W)) bus ();

   interval_timer_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Field order: cnt, busy, tick, done, irq, overrun, cfg_err
   assign obs = {bus.cnt, bus.busy, bus.tick, bus.done, bus.irq, bus.overrun, bus.cfg_err};

   function automatic logic [W+5:0] pack(input int c, input bit b, input bit t,
                                          input bit d, input bit i, input bit o,
                                          input bit er);
      return {W'(c), b, t, d, i, o, er};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_period  = '0;
      bus.cfg_oneshot = MODE_PERIODIC;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.pause       = 1'b0;
      bus.irq_ack     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.cfg_period = 8'd5;
      bus.start      = 1'b1;
      rst            = 1'b0;
      step();
      step();
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, {(W+6){1'b0}});
      end
      checks++;
      if (bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, IDLE);
      end
      bus.start = 1'b0;
      rst       = 1'b1;
   endtask

   task automatic test_periodic();
      do_reset();
      bus.cfg_period  = 8'd5;
      bus.cfg_oneshot = MODE_PERIODIC;
      for (int k = 0; k < 15; k++) begin
         bus.start = (k == 0);
         exp_q.push_back(pack(k % 5, 1, (k > 0) && (k % 5 == 0), 0, k >= 5, k >= 10, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL periodic k=%0d got=%h exp=%h", k, obs, e);
         end
      end
      bus.stop = 1'b1;
      exp_q.push_back(pack(0, 0, 0, 0, 1, 1, 0));
      step();
      bus.stop = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL stop_keeps_irq got=%h exp=%h", obs, e);
      end
      bus.irq_ack = 1'b1;
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      step();
      bus.irq_ack = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL ack_clears got=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_oneshot();
      do_reset();
      bus.cfg_period  = 8'd3;
      bus.cfg_oneshot = MODE_ONESHOT;
      for (int k = 0; k < 7; k++) begin
         bus.start = (k == 0);
         exp_q.push_back(pack((k < 3) ? k : 0, k < 3, k == 3, k >= 3, k >= 3, 0, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL oneshot k=%0d got=%h exp=%h", k, obs, e);
         end
      end
      bus.start = 1'b1;
      exp_q.push_back(pack(0, 1, 0, 0, 1, 0, 0));
      step();
      bus.start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL oneshot_restart got=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_pause();
      int c;
      do_reset();
      bus.cfg_period  = 8'd10;
      bus.cfg_oneshot = MODE_PERIODIC;
      for (int k = 0; k < 18; k++) begin
         bus.start = (k == 0);
         bus.pause = (k >= 5) && (k <= 10);
         c = (k <= 4) ? k : ((k <= 10) ? 4 : (k - 6) % 10);
         exp_q.push_back(pack(c, 1, k == 16, 0, k >= 16, 0, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL pause k=%0d got=%h exp=%h", k, obs, e);
         end
         if (k == 8) begin
            checks++;
            if (bus.dbg_state !== HOLD) begin
               failures++;
               $display("FAIL pause_state got=%0d exp=%0d", bus.dbg_state, HOLD);
            end
         end
      end
      bus.pause = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      bus.cfg_period  = 8'd10;
      bus.cfg_oneshot = MODE_PERIODIC;
      for (int k = 0; k < 11; k++) begin
         bus.start = (k == 0) || (k == 8);
         exp_q.push_back(pack((k < 8) ? k : k - 8, 1, 0, 0, 0, 0, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL restart k=%0d got=%h exp=%h", k, obs, e);
         end
      end
      bus.stop  = 1'b1;
      bus.start = 1'b1;
      bus.pause = 1'b1;
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL stop_start_pause got=%h/%0d exp=%h/%0d", obs, bus.dbg_state, e, IDLE);
      end
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL idle_pause got=%h/%0d exp=%h/%0d", obs, bus.dbg_state, e, IDLE);
      end
      bus.pause = 1'b0;
   endtask

   task automatic test_irq_overrun();
      do_reset();
      bus.cfg_period  = 8'd2;
      bus.cfg_oneshot = MODE_PERIODIC;
      for (int k = 0; k < 9; k++) begin
         bus.start   = (k == 0);
         bus.irq_ack = (k == 4) || (k == 7);
         exp_q.push_back(pack(k % 2, 1, (k >= 2) && (k % 2 == 0), 0,
                              (k >= 2) && (k != 7), k == 6, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL irq k=%0d got=%h exp=%h", k, obs, e);
         end
      end
      bus.irq_ack = 1'b0;
   endtask

   task automatic test_edges();
      do_reset();
      bus.cfg_period = 8'd0;
      bus.start      = 1'b1;
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 1));
      step();
      bus.start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL p0_err got=%h/%0d exp=%h/%0d", obs, bus.dbg_state, e, IDLE);
      end
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL p0_err_clear got=%h exp=%h", obs, e);
      end

      bus.cfg_period = 8'd1;
      for (int k = 0; k < 5; k++) begin
         bus.start = (k == 0);
         exp_q.push_back(pack(0, 1, k >= 1, 0, k >= 1, k >= 2, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL p1 k=%0d got=%h exp=%h", k, obs, e);
         end
      end

      do_reset();
      bus.cfg_period = 8'd255;
      for (int k = 0; k < 258; k++) begin
         bus.start = (k == 0);
         exp_q.push_back(pack(k % 255, 1, k == 255, 0, k >= 255, 0, 0));
         step();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL p255 k=%0d got=%h exp=%h", k, obs, e);
         end
      end

      rst = 1'b0;
      #2;
      checks++;
      if (obs !== '0 || bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL async_rst got=%h/%0d exp=%h/%0d", obs, bus.dbg_state,
                  {(W+6){1'b0}}, IDLE);
      end
      #1;
      rst = 1'b1;
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL post_rst_idle got=%h exp=%h", obs, e);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_periodic();
      test_oneshot();
      test_pause();
      test_priority();
      test_irq_overrun();
      test_edges();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
